// File: rtl/acc_mq_seq_alu_if.sv
// Bus/handshake bundle for acc_mq_seq_alu: opcode, start/rdy/done handshake,
// register load/store strobes, data buses and the carry flag.
interface acc_mq_seq_alu_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       ins;
  logic             start;
  logic             ld_acc;
  logic             ld_mq;
  logic             ld_dr;
  logic             st_acc;
  logic             st_mq;
  logic             st_dr;
  logic [WIDTH-1:0] in_bus;
  logic [WIDTH-1:0] out_bus;
  logic             rdy;
  logic             done;
  logic             carry;

  modport master (
    output ins, start, ld_acc, ld_mq, ld_dr, st_acc, st_mq, st_dr, in_bus,
    input  out_bus, rdy, done, carry
  );

  modport slave (
    input  ins, start, ld_acc, ld_mq, ld_dr, st_acc, st_mq, st_dr, in_bus,
    output out_bus, rdy, done, carry
  );
endinterface

// File: rtl/acc_mq_seq_alu.sv
// Acc/MQ/DR datapath with single-cycle ALU ops, SHR and a WIDTH-step shift-add multiply.
// Optional macro ACC_SAT_EN: ADD/SUB saturate on carry-out/borrow instead of wrapping.
module acc_mq_seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  acc_mq_seq_alu_if.slave      bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] dr_q, dr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH:0]   add_res;
  logic [WIDTH:0]   sub_res;
  logic [WIDTH:0]   mul_sum;

  // Top bit of the result is the carry-out.
  function automatic logic [WIDTH:0] add_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef ACC_SAT_EN
    if (s[WIDTH]) s[WIDTH-1:0] = '1;
`endif
    return s;
  endfunction

  // Top bit of the result is the borrow (set iff a < b).
  function automatic logic [WIDTH:0] sub_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
`ifdef ACC_SAT_EN
    if (d[WIDTH]) d[WIDTH-1:0] = '0;
`endif
    return d;
  endfunction

  assign add_res = add_op(acc_q, dr_q);
  assign sub_res = sub_op(acc_q, dr_q);
  assign mul_sum = mq_q[0] ? ({1'b0, acc_q} + {1'b0, dr_q}) : {1'b0, acc_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    dr_d    = dr_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_DONE;
          case (bus.ins)
            3'b000: begin acc_d = add_res[WIDTH-1:0]; carry_d = add_res[WIDTH]; end
            3'b001: begin acc_d = sub_res[WIDTH-1:0]; carry_d = sub_res[WIDTH]; end
            3'b010: begin acc_d = acc_q & dr_q; carry_d = 1'b0; end
            3'b011: begin acc_d = acc_q | dr_q; carry_d = 1'b0; end
            3'b100: begin acc_d = acc_q ^ dr_q; carry_d = 1'b0; end
            3'b101: begin
              acc_d   = '0;
              cnt_d   = CNT_W'(WIDTH);
              carry_d = 1'b0;
              state_d = S_MUL;
            end
            3'b110: begin
              acc_d   = {carry_q, acc_q[WIDTH-1:1]};
              mq_d    = {acc_q[0], mq_q[WIDTH-1:1]};
              carry_d = 1'b0;
            end
            default: begin acc_d = dr_q; carry_d = 1'b0; end
          endcase
        end else begin
          if (bus.ld_acc) acc_d = bus.in_bus;
          if (bus.ld_mq)  mq_d  = bus.in_bus;
          if (bus.ld_dr)  dr_d  = bus.in_bus;
        end
      end
      // One shift-add step per cycle; the product's low half shifts into MQ.
      S_MUL: begin
        acc_d = mul_sum[WIDTH:1];
        mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
    rdy_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mq_q    <= '0;
      dr_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      dr_q    <= dr_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.out_bus = ({WIDTH{bus.st_acc}} & acc_q)
                     | ({WIDTH{bus.st_mq}}  & mq_q)
                     | ({WIDTH{bus.st_dr}}  & dr_q);
  assign bus.rdy     = rdy_q;
  assign bus.done    = done_q;
  assign bus.carry   = carry_q;

endmodule

// File: tb/tb_acc_mq_seq_alu.sv
// Self-checking bench for acc_mq_seq_alu (WIDTH=8): arithmetic reference model plus
// directed vectors; honours ACC_SAT_EN when the macro is defined.
module tb_acc_mq_seq_alu;
  localparam int W = 8;
  localparam longint MOD = 64'd1 << W;

`ifdef ACC_SAT_EN
  localparam longint E_ADD = 255, E_SUB1 = 0, E_SHR_ACC = 8'hFF, E_SHR_MQ = 8'h87;
`else
  localparam longint E_ADD = 44, E_SUB1 = 254, E_SHR_ACC = 8'h96, E_SHR_MQ = 8'h07;
`endif

  logic clock;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  acc_mq_seq_alu_if #(.WIDTH(W)) bus ();
  acc_mq_seq_alu #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input longint exp);
    n_cmp++;
    if (got !== 64'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: ALU ops by plain arithmetic, MUL intermediates from the
  // closed form {Acc,MQ} after k steps = ((MQ0 mod 2^k)*DR << (W-k)) + (MQ0 >> k).
  longint m_acc, m_mq, m_dr, m_mq0;
  int     m_k;
  bit     m_carry, m_mul, m_done;
  wire    m_rdy = !(m_mul || m_done);

  always @(posedge clock or posedge reset) begin : model
    longint s, v;
    if (reset) begin
      m_acc <= 0; m_mq <= 0; m_dr <= 0; m_mq0 <= 0; m_k <= 0;
      m_carry <= 0; m_mul <= 0; m_done <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_mul) begin
      v = (((m_mq0 & ((64'd1 << (m_k + 1)) - 1)) * m_dr) << (W - m_k - 1)) | (m_mq0 >> (m_k + 1));
      m_acc <= v >> W;
      m_mq  <= v % MOD;
      m_k   <= m_k + 1;
      if (m_k + 1 == W) begin m_mul <= 0; m_done <= 1; end
    end else if (bus.start) begin
      m_done <= 1;
      case (bus.ins)
        3'd0: begin
          s = m_acc + m_dr;
          m_carry <= (s >= MOD);
`ifdef ACC_SAT_EN
          m_acc <= (s >= MOD) ? MOD - 1 : s;
`else
          m_acc <= s % MOD;
`endif
        end
        3'd1: begin
          m_carry <= (m_acc < m_dr);
`ifdef ACC_SAT_EN
          m_acc <= (m_acc < m_dr) ? 0 : m_acc - m_dr;
`else
          m_acc <= (m_acc - m_dr + MOD) % MOD;
`endif
        end
        3'd2: begin m_acc <= m_acc & m_dr; m_carry <= 0; end
        3'd3: begin m_acc <= m_acc | m_dr; m_carry <= 0; end
        3'd4: begin m_acc <= m_acc ^ m_dr; m_carry <= 0; end
        3'd5: begin
          m_done <= 0; m_mul <= 1; m_k <= 0; m_mq0 <= m_mq; m_acc <= 0; m_carry <= 0;
        end
        3'd6: begin
          m_acc <= m_carry * (MOD / 2) + m_acc / 2;
          m_mq  <= (m_acc % 2) * (MOD / 2) + m_mq / 2;
          m_carry <= 0;
        end
        default: begin m_acc <= m_dr; m_carry <= 0; end
      endcase
    end else begin
      if (bus.ld_acc) m_acc <= bus.in_bus;
      if (bus.ld_mq)  m_mq  <= bus.in_bus;
      if (bus.ld_dr)  m_dr  <= bus.in_bus;
    end
  end

  // Cycle-by-cycle compare of every output against the model.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        chk("rdy", bus.rdy, m_rdy);
        chk("done", bus.done, m_done);
        chk("carry", bus.carry, m_carry);
        chk("out_bus", bus.out_bus,
            (bus.st_acc ? m_acc : 0) | (bus.st_mq ? m_mq : 0) | (bus.st_dr ? m_dr : 0));
      end
    end
  end

  task automatic clear_inputs();
    bus.ins = 3'd0; bus.start = 0; bus.ld_acc = 0; bus.ld_mq = 0; bus.ld_dr = 0;
    bus.st_acc = 0; bus.st_mq = 0; bus.st_dr = 0; bus.in_bus = '0;
  endtask

  task automatic load(input logic a, input logic m, input logic d, input logic [W-1:0] val);
    @(negedge clock);
    bus.ld_acc = a; bus.ld_mq = m; bus.ld_dr = d; bus.in_bus = val;
    @(posedge clock);
    #1;
    bus.ld_acc = 0; bus.ld_mq = 0; bus.ld_dr = 0;
  endtask

  task automatic rd(input logic a, input logic m, input logic d, output logic [W-1:0] val);
    @(negedge clock);
    bus.st_acc = a; bus.st_mq = m; bus.st_dr = d;
    #1 val = bus.out_bus;
    #1;
    bus.st_acc = 0; bus.st_mq = 0; bus.st_dr = 0;
  endtask

  // Issues an op and returns the number of edges (start edge = 1) until done.
  // junk=1 hammers ld_dr/start while busy; with_ld=1 asserts ld_acc with start.
  task automatic run_op(input logic [2:0] op, input bit junk, input bit with_ld, output int lat);
    @(negedge clock);
    bus.ins = op; bus.start = 1; bus.ld_acc = with_ld; bus.in_bus = 8'h99;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      bus.start = junk; bus.ld_acc = 0; bus.ld_dr = junk; bus.in_bus = 8'h55;
      bus.ins = junk ? 3'd7 : op;
      if (bus.done) begin lat = i; break; end
    end
    bus.start = 0; bus.ld_dr = 0; bus.in_bus = '0;
    if (lat == 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    logic [W-1:0] v;
    int lat;
    clear_inputs();
    reset = 0;
    #1 reset = 1;
    repeat (3) @(negedge clock);
    reset = 0;
    @(posedge clock); #1;
    chk("reset_rdy", bus.rdy, 1);
    chk("reset_done", bus.done, 0);
    chk("reset_carry", bus.carry, 0);
    rd(1, 1, 1, v); chk("reset_regs", v, 0);

    // ADD with overflow
    load(1, 0, 0, 8'd200); load(0, 0, 1, 8'd100);
    run_op(3'd0, 0, 0, lat);
    chk("add_lat", lat, 1);
    chk("add_done", bus.done, 1);
    chk("add_carry", bus.carry, 1);
    chk("mdl_add", m_acc, E_ADD);
    rd(1, 0, 0, v); chk("add_acc", v, E_ADD);

    // SHR shifts carry=1 into Acc MSB
    load(0, 1, 0, 8'h0F);
    run_op(3'd6, 0, 0, lat);
    chk("shr_carry", bus.carry, 0);
    rd(1, 0, 0, v); chk("shr_acc", v, E_SHR_ACC);
    rd(0, 1, 0, v); chk("shr_mq", v, E_SHR_MQ);
    chk("mdl_shr", m_acc, E_SHR_ACC);

    // SUB with and without borrow
    load(1, 0, 0, 8'd5); load(0, 0, 1, 8'd7);
    run_op(3'd1, 0, 0, lat);
    chk("sub_borrow", bus.carry, 1);
    rd(1, 0, 0, v); chk("sub_acc1", v, E_SUB1);
    load(1, 0, 0, 8'd7); load(0, 0, 1, 8'd5);
    run_op(3'd1, 0, 0, lat);
    chk("sub_noborrow", bus.carry, 0);
    rd(1, 0, 0, v); chk("sub_acc2", v, 2);

    // Logic ops
    load(1, 0, 0, 8'hF0); load(0, 0, 1, 8'h3C);
    run_op(3'd2, 0, 0, lat); rd(1, 0, 0, v); chk("and_acc", v, 8'h30);
    run_op(3'd4, 0, 0, lat); rd(1, 0, 0, v); chk("xor_acc", v, 8'h0C);
    run_op(3'd3, 0, 0, lat); rd(1, 0, 0, v); chk("or_acc", v, 8'h3C);

    // MUL 13*11
    load(0, 1, 0, 8'd13); load(0, 0, 1, 8'd11);
    run_op(3'd5, 0, 0, lat);
    chk("mul_lat", lat, W + 1);
    chk("mul_carry", bus.carry, 0);
    rd(1, 0, 0, v); chk("mul_acc", v, 8'h00);
    rd(0, 1, 0, v); chk("mul_mq", v, 8'h8F);
    chk("mdl_mul", m_mq, 8'h8F);

    // MUL 255*255
    load(0, 1, 1, 8'd255);
    run_op(3'd5, 0, 0, lat);
    chk("mul255_lat", lat, W + 1);
    rd(1, 0, 0, v); chk("mul255_acc", v, 8'hFE);
    rd(0, 1, 0, v); chk("mul255_mq", v, 8'h01);

    // MUL by zero still takes WIDTH cycles
    load(0, 1, 0, 8'h5A); load(0, 0, 1, 8'h00);
    run_op(3'd5, 0, 0, lat);
    chk("mul0_lat", lat, W + 1);
    rd(1, 1, 0, v); chk("mul0_res", v, 0);

    // Busy lockout: ld_dr/start during MUL are ignored
    load(0, 1, 0, 8'd13); load(0, 0, 1, 8'd11);
    run_op(3'd5, 1, 0, lat);
    chk("lock_lat", lat, W + 1);
    rd(0, 1, 0, v); chk("lock_mq", v, 8'h8F);
    rd(0, 0, 1, v); chk("lock_dr", v, 8'd11);

    // start beats ld_acc in the same IDLE cycle
    load(1, 0, 0, 8'd7); load(0, 0, 1, 8'd5);
    run_op(3'd7, 0, 1, lat);
    rd(1, 0, 0, v); chk("start_prio", v, 8'd5);

    // Reset during the 4th MUL cycle
    load(0, 1, 0, 8'd13); load(0, 0, 1, 8'd11);
    @(negedge clock); bus.ins = 3'd5; bus.start = 1;
    @(posedge clock); #1 bus.start = 0;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1;
    #1;
    chk("rst_rdy", bus.rdy, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_carry", bus.carry, 0);
    bus.st_acc = 1; bus.st_mq = 1; bus.st_dr = 1;
    #1 chk("rst_regs", bus.out_bus, 0);
    bus.st_acc = 0; bus.st_mq = 0; bus.st_dr = 0;
    @(negedge clock); reset = 0;
    load(0, 0, 1, 8'h3A);
    run_op(3'd7, 0, 0, lat);
    chk("pass_lat", lat, 1);
    rd(1, 0, 0, v); chk("pass_acc", v, 8'h3A);

    // Store bus OR and idle bus
    load(1, 0, 0, 8'hF0); load(0, 1, 0, 8'h0F);
    rd(1, 1, 0, v); chk("bus_or", v, 8'hFF);
    rd(0, 0, 0, v); chk("bus_none", v, 8'h00);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
